// File: rtl/ah_cpu2pl_pkg.sv
// Shared constants for the CPU-to-PL AXI-Lite write path (slave, command FIFO, PL consumers).
package ah_cpu2pl_pkg;
  localparam int AH_CPU2PL_IDX_WIDTH      = 5;
  localparam int AH_CPU2PL_MAX_PORTS      = 32;
  localparam int AH_CPU2PL_DROP_CNT_WIDTH = 16;
endpackage

// File: rtl/ah_cpu2pl_cmd_fifo_mem.sv
// Command FIFO storage: DEPTH x WIDTH register array, one synchronous write port and one async read port.
module ah_cpu2pl_cmd_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 37,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents need no reset: the read side is qualified by the level counter.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/ah_cpu2pl_cmd_fifo.sv
// Captures AXI-Lite slave register writes as {index, data} commands into a FIFO with valid/ready output.
// Optional saturating drop counter: define AH_CPU2PL_CMD_FIFO_DROP_CNT_EN.
module ah_cpu2pl_cmd_fifo
  import ah_cpu2pl_pkg::*;
#(
  parameter int USED_OUTPUTS = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESETN,
  input  logic [DATA_WIDTH*USED_OUTPUTS-1:0] output_write,
  input  logic [USED_OUTPUTS-1:0]            intr_output,
  output logic                               intr_busy,
  output logic                               cmd_valid,
  input  logic                               cmd_ready,
  output logic [AH_CPU2PL_IDX_WIDTH-1:0]     cmd_index,
  output logic [DATA_WIDTH-1:0]              cmd_data,
  output logic [$clog2(DEPTH):0]             level,
  output logic                               overflow,
  output logic                               multi_hit,
  input  logic                               clr_flags,
  output logic [AH_CPU2PL_DROP_CNT_WIDTH-1:0] drop_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = AH_CPU2PL_IDX_WIDTH + DATA_WIDTH;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d, multi_hit_q, multi_hit_d;

  logic [AH_CPU2PL_IDX_WIDTH-1:0] push_idx;
  logic [DATA_WIDTH-1:0]          push_data;
  logic                           push_req, multi, full, pop, push_ok, drop;
  logic [ENT_W-1:0]               head;

  // Lowest set bit wins: scan high to low so the last match is the lowest index.
  always_comb begin
    push_idx  = '0;
    push_data = '0;
    for (int i = USED_OUTPUTS - 1; i >= 0; i--) begin
      if (intr_output[i]) begin
        push_idx  = AH_CPU2PL_IDX_WIDTH'(i);
        push_data = output_write[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign push_req = |intr_output;
  assign multi    = (intr_output & (intr_output - USED_OUTPUTS'(1))) != '0;
  assign full     = level_q == LVL_W'(DEPTH);
  assign pop      = cmd_valid && cmd_ready;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    wr_ptr_d    = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d     = level_q + LVL_W'(push_ok) - LVL_W'(pop);
    overflow_d  = clr_flags ? 1'b0 : (overflow_q | drop);
    multi_hit_d = clr_flags ? 1'b0 : (multi_hit_q | multi);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      multi_hit_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      multi_hit_q <= multi_hit_d;
    end
  end

`ifdef AH_CPU2PL_CMD_FIFO_DROP_CNT_EN
  logic [AH_CPU2PL_DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_flags)                 drop_cnt_d = '0;
    else if (drop && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + AH_CPU2PL_DROP_CNT_WIDTH'(1);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) drop_cnt_q <= '0;
    else                drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

  ah_cpu2pl_cmd_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk   (S_AXI_ACLK),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata ({push_idx, push_data}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  // Head is masked while empty so outputs read zero after reset.
  assign cmd_valid = level_q != '0;
  assign cmd_index = cmd_valid ? head[ENT_W-1 -: AH_CPU2PL_IDX_WIDTH] : '0;
  assign cmd_data  = cmd_valid ? head[DATA_WIDTH-1:0] : '0;
  assign intr_busy = level_q >= LVL_W'(DEPTH - 1);
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign multi_hit = multi_hit_q;
endmodule

// File: tb/tb_ah_cpu2pl_cmd_fifo.sv
// Directed bench for ah_cpu2pl_cmd_fifo (USED_OUTPUTS=4, DATA_WIDTH=32, DEPTH=8).
module tb_ah_cpu2pl_cmd_fifo;
  localparam int NO = 4, DW = 32, DEPTH = 8;

  logic            clk = 0, rst_n = 0;
  logic [DW*NO-1:0] output_write = '0;
  logic [NO-1:0]   intr_output = '0;
  logic            intr_busy, cmd_valid, cmd_ready = 0, overflow, multi_hit, clr_flags = 0;
  logic [4:0]      cmd_index;
  logic [DW-1:0]   cmd_data;
  logic [3:0]      level;
  logic [15:0]     drop_count;

  int n_chk = 0, n_bad = 0;
  logic [4:0]    q_idx [$];
  logic [DW-1:0] q_dat [$];

  always #5 clk = ~clk;

  ah_cpu2pl_cmd_fifo #(.USED_OUTPUTS(NO), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .output_write(output_write),
    .intr_output(intr_output), .intr_busy(intr_busy), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_index(cmd_index), .cmd_data(cmd_data), .level(level),
    .overflow(overflow), .multi_hit(multi_hit), .clr_flags(clr_flags), .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one pulse for register idx carrying dat, for one cycle.
  task automatic pulse(input int idx, input logic [DW-1:0] dat);
    output_write[idx*DW +: DW] = dat;
    intr_output = NO'(1) << idx;
    tick();
    intr_output = '0;
  endtask

  task automatic chk_head(input string tag, input logic [4:0] idx, input logic [DW-1:0] dat);
    chk({tag, "_vld"}, cmd_valid, 1);
    chk({tag, "_idx"}, cmd_index, idx);
    chk({tag, "_dat"}, cmd_data, dat);
  endtask

  initial begin
    logic [15:0] exp_drop;
    #12;
    chk("rst_vld", cmd_valid, 0);
    chk("rst_lvl", level, 0);
    chk("rst_busy", intr_busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_mh", multi_hit, 0);
    chk("rst_idx", cmd_index, 0);
    chk("rst_dat", cmd_data, 0);
    chk("rst_drop", drop_count, 0);
    rst_n = 1;
    tick();

    // Single push, one-cycle latency, then pop.
    pulse(2, 32'hDEADBEEF);
    chk_head("single", 5'd2, 32'hDEADBEEF);
    chk("single_lvl", level, 1);
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    chk("single_pop_vld", cmd_valid, 0);
    chk("single_pop_lvl", level, 0);

    // Fill to full with cmd_ready low.
    for (int k = 0; k < 8; k++) begin
      pulse(k % 4, 32'h100 + k);
      q_idx.push_back(5'(k % 4));
      q_dat.push_back(32'h100 + k);
      if (k == 5) chk("fill6_busy", intr_busy, 0);
      if (k == 6) begin
        chk("fill7_busy", intr_busy, 1);
        chk("fill7_lvl", level, 7);
      end
    end
    chk("fill8_lvl", level, 8);
    chk_head("fill_head", 5'd0, 32'h100);
    pulse(1, 32'h999);
    chk("drop_lvl", level, 8);
    chk("drop_ovf", overflow, 1);
`ifdef AH_CPU2PL_CMD_FIFO_DROP_CNT_EN
    exp_drop = 16'd1;
`else
    exp_drop = 16'd0;
`endif
    chk("drop_cnt", drop_count, exp_drop);
    chk_head("drop_head", 5'd0, 32'h100);

    clr_flags = 1;
    tick();
    clr_flags = 0;
    chk("clr_ovf", overflow, 0);
    chk("clr_drop", drop_count, 0);

    // Full: simultaneous push and pop keeps level at DEPTH.
    cmd_ready = 1;
    pulse(3, 32'hABC);
    cmd_ready = 0;
    void'(q_idx.pop_front());
    void'(q_dat.pop_front());
    q_idx.push_back(5'd3);
    q_dat.push_back(32'hABC);
    chk("fullpp_lvl", level, 8);
    chk("fullpp_ovf", overflow, 0);
    cmd_ready = 1;
    for (int k = 0; k < 8; k++) begin
      chk_head($sformatf("drain%0d", k), q_idx.pop_front(), q_dat.pop_front());
      tick();
    end
    cmd_ready = 0;
    chk("drain_vld", cmd_valid, 0);

    // multi_hit: lowest index only, then clear.
    output_write[1*DW +: DW] = 32'h11;
    output_write[3*DW +: DW] = 32'h33;
    intr_output = 4'b1010;
    tick();
    intr_output = '0;
    chk("mh_flag", multi_hit, 1);
    chk("mh_lvl", level, 1);
    chk_head("mh", 5'd1, 32'h11);
    clr_flags = 1;
    tick();
    clr_flags = 0;
    chk("mh_clr", multi_hit, 0);
    // Clear wins over a same-cycle set.
    output_write[0*DW +: DW] = 32'h22;
    intr_output = 4'b0011;
    clr_flags = 1;
    tick();
    intr_output = '0;
    clr_flags = 0;
    chk("mh_clrprio", multi_hit, 0);
    chk("mh_lvl2", level, 2);
    cmd_ready = 1;
    tick();
    chk_head("mh_second", 5'd0, 32'h22);
    tick();
    cmd_ready = 0;
    chk("mh_empty", cmd_valid, 0);

    // Asynchronous reset with 5 entries queued.
    for (int k = 0; k < 5; k++) pulse(k % 4, 32'h700 + k);
    chk("ar_lvl5", level, 5);
    #2;
    rst_n = 0;
    #1;
    chk("ar_vld", cmd_valid, 0);
    chk("ar_lvl", level, 0);
    chk("ar_busy", intr_busy, 0);
    chk("ar_idx", cmd_index, 0);
    #4;
    rst_n = 1;
    tick();
    chk("ar_post_vld", cmd_valid, 0);
    pulse(3, 32'hCAFE);
    chk_head("ar_post", 5'd3, 32'hCAFE);
    chk("ar_post_lvl", level, 1);
    cmd_ready = 1;
    tick();
    chk("ar_post_pop", cmd_valid, 0);

    // Streaming 20 pushes through a wrapping pointer with cmd_ready high.
    for (int k = 0; k < 20; k++) begin
      pulse(k % 4, 32'h5000 + k);
      chk_head($sformatf("wrap%0d", k), 5'(k % 4), 32'h5000 + k);
      chk($sformatf("wrap%0d_busy", k), intr_busy, 0);
      chk($sformatf("wrap%0d_lvl", k), level, 1);
    end
    tick();
    chk("wrap_end_vld", cmd_valid, 0);
    cmd_ready = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
